// File: rtl/uart_rx_ctrl.sv
// UART receive front end: synchronises rx, validates the start bit, majority-votes each bit at
// mid-bit on a CLK_DIV-divided oversample tick, and reports frame completion or framing errors.
module uart_rx_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 shift_bit,
  output logic                 shift_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int MID = OVERSAMPLE / 2;
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SAMP_A    = SW'(MID - 1);
  localparam logic [SW-1:0] SAMP_B    = SW'(MID);
  localparam logic [SW-1:0] SAMP_DEC  = SW'(MID + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t                 state;
  logic                   rx_p0, rx_s, rx_prev;
  logic                   vld_p0, vld_p1, vld_prev;
  logic [DW-1:0]          div_cnt;
  logic [SW-1:0]          samp_cnt;
  logic [BW-1:0]          bit_cnt;
  logic                   samp_a, samp_b;
  logic [DATA_BITS-1:0]   rx_shadow;
  logic                   tick, decide, vote, fall;

  // Stage p0/p1: two-flop synchroniser; valid bits keep reset-time flop contents from
  // masquerading as a real high line, so a line held low through reset is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_p0    <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_prev <= 1'b0;
    end else begin
      rx_p0    <= rx;
      rx_s     <= rx_p0;
      rx_prev  <= rx_s;
      vld_p0   <= 1'b1;
      vld_p1   <= vld_p0;
      vld_prev <= vld_p1;
    end
  end

  assign fall   = vld_prev & rx_prev & ~rx_s;
  assign tick   = (div_cnt == DIV_LAST);
  assign decide = tick && (samp_cnt == SAMP_DEC);
  assign vote   = vote3(samp_a, samp_b, rx_s);
  assign busy   = (state != IDLE);

  // Stage p2: tick generation, mid-bit sampling and frame FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      samp_a    <= 1'b1;
      samp_b    <= 1'b1;
      rx_shadow <= '0;
      rx_data   <= '0;
      shift_bit <= 1'b0;
      shift_en  <= 1'b0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      shift_en  <= 1'b0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;

      // Counters sit at zero while idle so the tick phase starts fresh at the start edge.
      if (state == IDLE) begin
        div_cnt  <= '0;
        samp_cnt <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
          if (samp_cnt == SAMP_A) samp_a <= rx_s;
          if (samp_cnt == SAMP_B) samp_b <= rx_s;
        end
      end

      case (state)
        IDLE: begin
          if (fall) state <= START;
        end
        START: begin
          if (decide) begin
            if (!vote) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (decide) begin
            shift_bit          <= vote;
            shift_en           <= 1'b1;
            rx_shadow[bit_cnt] <= vote;
            if (bit_cnt == BIT_LAST) state <= STOP;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (decide) begin
            if (vote) begin
              rx_data <= rx_shadow;
              rx_done <= 1'b1;
              state   <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: serial frames driven bit by bit, strobes collected by a
// monitor and compared against byte/bit expectations derived from the frame format.
module tb_uart_rx_ctrl;

  localparam int BIT_T = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       shift_bit, shift_en, rx_done, frame_err, busy;
  logic [7:0] rx_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] last_good = 8'h00;

  logic       bits_q[$];
  logic [7:0] done_q[$];
  int ferr_cnt = 0;
  int overlap_cnt = 0;
  int last_shift_cyc = 0;
  int done_cyc = 0;

  uart_rx_ctrl #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .shift_bit(shift_bit), .shift_en(shift_en), .rx_data(rx_data),
    .rx_done(rx_done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (shift_en) begin
      bits_q.push_back(shift_bit);
      last_shift_cyc = cyc;
    end
    if (rx_done) begin
      done_q.push_back(rx_data);
      done_cyc = cyc;
    end
    if (frame_err) ferr_cnt++;
    if (int'(shift_en) + int'(rx_done) + int'(frame_err) > 1) overlap_cnt++;
  end

  task automatic send_bit(input logic v);
    rx = v;
    repeat (BIT_T) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    int nb, nd;
    rx = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({shift_bit, shift_en, rx_data, rx_done, frame_err, busy} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {shift_bit, shift_en, rx_data, rx_done, frame_err, busy});
    end
    nb = bits_q.size(); nd = done_q.size();
    rst = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL low_line_after_reset_busy: got %0b expected 0", busy);
    end
    checks++;
    if (bits_q.size() != nb || done_q.size() != nd || ferr_cnt != 0) begin
      failures++;
      $display("FAIL low_line_after_reset_strobes: got %0d expected 0",
               bits_q.size() - nb + done_q.size() - nd + ferr_cnt);
    end
    idle(20);
  endtask

  task automatic test_frame(input logic [7:0] d);
    int nb, nd, nf;
    nb = bits_q.size(); nd = done_q.size(); nf = ferr_cnt;
    send_frame(d, 1'b1);
    idle(20);
    checks++;
    if (bits_q.size() - nb != 8) begin
      failures++;
      $display("FAIL frame_shift_count: got %0d expected 8", bits_q.size() - nb);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (bits_q[nb + i] !== d[i]) begin
          failures++;
          $display("FAIL frame_shift_bit%0d: got %0b expected %0b", i, bits_q[nb + i], d[i]);
        end
      end
    end
    checks++;
    if (done_q.size() - nd != 1 || rx_data !== d) begin
      failures++;
      $display("FAIL frame_done: got count %0d data %0h expected 1 data %0h",
               done_q.size() - nd, rx_data, d);
    end
    checks++;
    if (ferr_cnt != nf) begin
      failures++;
      $display("FAIL frame_no_err: got %0d expected 0", ferr_cnt - nf);
    end
    checks++;
    if (done_cyc - last_shift_cyc != BIT_T) begin
      failures++;
      $display("FAIL frame_done_latency: got %0d expected %0d", done_cyc - last_shift_cyc, BIT_T);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL frame_busy_idle: got %0b expected 0", busy);
    end
    last_good = d;
  endtask

  task automatic test_glitch_start();
    int nb, nd, n;
    bit seen_busy, dropped;
    nb = bits_q.size(); nd = done_q.size();
    seen_busy = 0; dropped = 0;
    rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1;
    end
    rx = 1'b1;
    n = 0;
    while (n < BIT_T && !dropped) begin
      @(negedge clk);
      if (busy) seen_busy = 1;
      else if (seen_busy) dropped = 1;
      n++;
    end
    checks++;
    if (!(seen_busy && dropped)) begin
      failures++;
      $display("FAIL glitch_start_busy: got entered %0b dropped %0b expected 1 1", seen_busy, dropped);
    end
    idle(100);
    checks++;
    if (bits_q.size() != nb || done_q.size() != nd) begin
      failures++;
      $display("FAIL glitch_start_strobes: got %0d expected 0", bits_q.size() - nb + done_q.size() - nd);
    end
  endtask

  task automatic test_frame_err();
    int nd, nf;
    nd = done_q.size(); nf = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (300) @(negedge clk);
    idle(BIT_T);
    checks++;
    if (ferr_cnt - nf != 1) begin
      failures++;
      $display("FAIL frame_err_count: got %0d expected 1", ferr_cnt - nf);
    end
    checks++;
    if (done_q.size() != nd || rx_data !== last_good) begin
      failures++;
      $display("FAIL frame_err_data_held: got %0h expected %0h", rx_data, last_good);
    end
    checks++;
    if (overlap_cnt != 0) begin
      failures++;
      $display("FAIL strobe_overlap: got %0d expected 0", overlap_cnt);
    end
    test_frame(8'h81);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    int nb, nd, nf;
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h55;
    nb = bits_q.size(); nd = done_q.size(); nf = ferr_cnt;
    for (int f = 0; f < 3; f++) send_frame(exp[f], 1'b1);
    idle(20);
    checks++;
    if (done_q.size() - nd != 3 || bits_q.size() - nb != 24) begin
      failures++;
      $display("FAIL b2b_counts: got done %0d bits %0d expected 3 24",
               done_q.size() - nd, bits_q.size() - nb);
    end else begin
      for (int f = 0; f < 3; f++) begin
        checks++;
        if (done_q[nd + f] !== exp[f]) begin
          failures++;
          $display("FAIL b2b_data%0d: got %0h expected %0h", f, done_q[nd + f], exp[f]);
        end
      end
    end
    checks++;
    if (ferr_cnt != nf) begin
      failures++;
      $display("FAIL b2b_no_err: got %0d expected 0", ferr_cnt - nf);
    end
    last_good = 8'h55;
  endtask

  task automatic test_glitch_data();
    int nd, nb;
    nd = done_q.size(); nb = bits_q.size();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    rx = 1'b0;
    repeat (23) @(negedge clk);
    for (int i = 4; i < 8; i++) send_bit(1'b0);
    send_bit(1'b1);
    idle(20);
    checks++;
    if (done_q.size() - nd != 1 || rx_data !== 8'h00) begin
      failures++;
      $display("FAIL glitch_data: got count %0d data %0h expected 1 data 00", done_q.size() - nd, rx_data);
    end
    checks++;
    if (bits_q.size() - nb != 8 || bits_q[nb + 3] !== 1'b0) begin
      failures++;
      $display("FAIL glitch_data_bit3: got count %0d expected 8 with bit3 0", bits_q.size() - nb);
    end
    last_good = 8'h00;
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int nd, nb, nf, gap;
    nd = done_q.size(); nb = bits_q.size(); nf = ferr_cnt;
    for (int f = 0; f < 10; f++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      send_frame(d, 1'b1);
      gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 80);
      if (gap > 0) idle(gap);
    end
    idle(20);
    checks++;
    if (done_q.size() - nd != 10 || bits_q.size() - nb != 80) begin
      failures++;
      $display("FAIL random_counts: got done %0d bits %0d expected 10 80",
               done_q.size() - nd, bits_q.size() - nb);
    end else begin
      for (int f = 0; f < 10; f++) begin
        logic [7:0] got;
        for (int i = 0; i < 8; i++) got[i] = bits_q[nb + 8 * f + i];
        checks++;
        if (done_q[nd + f] !== exp_q[f] || got !== exp_q[f]) begin
          failures++;
          $display("FAIL random_frame%0d: got done %0h bits %0h expected %0h",
                   f, done_q[nd + f], got, exp_q[f]);
        end
      end
    end
    checks++;
    if (ferr_cnt != nf || overlap_cnt != 0) begin
      failures++;
      $display("FAIL random_err_overlap: got %0d %0d expected 0 0", ferr_cnt - nf, overlap_cnt);
    end
    last_good = exp_q[9];
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    int nd, nb, nf;
    d = 8'hF0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    repeat (30) @(negedge clk);
    rst = 1'b0;
    #1;
    nd = done_q.size(); nb = bits_q.size(); nf = ferr_cnt;
    checks++;
    if ({shift_bit, shift_en, rx_data, rx_done, frame_err, busy} !== 13'd0) begin
      failures++;
      $display("FAIL midframe_reset_outputs: got %0h expected 0",
               {shift_bit, shift_en, rx_data, rx_done, frame_err, busy});
    end
    repeat (5) @(negedge clk);
    rx = 1'b1;
    rst = 1'b1;
    idle(BIT_T * 8);
    checks++;
    if (bits_q.size() != nb || done_q.size() != nd || ferr_cnt != nf || busy !== 1'b0) begin
      failures++;
      $display("FAIL midframe_no_strobes: got %0d busy %0b expected 0 0",
               bits_q.size() - nb + done_q.size() - nd + ferr_cnt - nf, busy);
    end
    checks++;
    if (rx_data !== 8'h00) begin
      failures++;
      $display("FAIL midframe_data_cleared: got %0h expected 00", rx_data);
    end
    test_frame(8'h12);
  endtask

  initial begin
    rst = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_frame(8'hA5);
    test_glitch_start();
    test_frame_err();
    test_back_to_back();
    test_glitch_data();
    test_random();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
